// File: rtl/rgb_pkg.sv
// rtl/rgb_pkg.sv - shared pixel types for the RGB dispatch slice
package rgb_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int NUM_CH = 4;

endpackage

// File: rtl/rgb_out_slot.sv
// rtl/rgb_out_slot.sv - one registered output slot with ready/valid handshake
module rgb_out_slot
  import rgb_pkg::rgb_t;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  rgb_t pix,
  input  logic ready,
  output logic valid,
  output rgb_t data,
  output logic free
);

  logic valid_q, valid_d;
  rgb_t data_q, data_d;

  // A slot draining this cycle can accept a new pixel without a bubble.
  assign free = !valid_q || ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = pix;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/rgb_first_dispatch.sv
// rtl/rgb_first_dispatch.sv - routes each pixel to the lowest-indexed enabled free slot
module rgb_first_dispatch
  import rgb_pkg::rgb_t;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_r,
  input  logic [7:0]       in_g,
  input  logic [7:0]       in_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       en_in,
  output logic [7:0]       out1_r,
  output logic [7:0]       out1_g,
  output logic [7:0]       out1_b,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [7:0]       out2_r,
  output logic [7:0]       out2_g,
  output logic [7:0]       out2_b,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [7:0]       out3_r,
  output logic [7:0]       out3_g,
  output logic [7:0]       out3_b,
  output logic             out3_valid,
  input  logic             out3_ready,
  output logic [7:0]       out4_r,
  output logic [7:0]       out4_g,
  output logic [7:0]       out4_b,
  output logic             out4_valid,
  input  logic             out4_ready,
  output logic [CNT_W-1:0] dispatch_cnt
);

  rgb_t        pix;
  rgb_t        slot_data [4];
  logic [3:0]  slot_valid, slot_free, slot_ready, cand, target, load;
  logic        xfer;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign pix        = '{r: in_r, g: in_g, b: in_b};
  assign slot_ready = {out4_ready, out3_ready, out2_ready, out1_ready};

  assign cand     = slot_free & en_in;
  // Isolate the lowest set bit: channel 1 wins ties.
  assign target   = cand & (~cand + 4'd1);
  assign in_ready = rst && (|cand);
  assign xfer     = in_valid && in_ready;
  assign load     = xfer ? target : 4'b0000;

  for (genvar i = 0; i < 4; i++) begin : g_slot
    rgb_out_slot u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[i]),
      .pix   (pix),
      .ready (slot_ready[i]),
      .valid (slot_valid[i]),
      .data  (slot_data[i]),
      .free  (slot_free[i])
    );
  end

  always_comb begin
    cnt_d = cnt_q;
    if (xfer) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign dispatch_cnt = cnt_q;

  assign {out1_r, out1_g, out1_b} = slot_data[0];
  assign {out2_r, out2_g, out2_b} = slot_data[1];
  assign {out3_r, out3_g, out3_b} = slot_data[2];
  assign {out4_r, out4_g, out4_b} = slot_data[3];
  assign {out4_valid, out3_valid, out2_valid, out1_valid} = slot_valid;

endmodule

// File: tb/tb_rgb_first_dispatch.sv
// tb/tb_rgb_first_dispatch.sv - directed self-checking bench for rgb_first_dispatch
module tb_rgb_first_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_r, in_g, in_b;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  en_in;
  logic [3:0]  rdy;
  logic [7:0]  o1r, o1g, o1b, o2r, o2g, o2b, o3r, o3g, o3b, o4r, o4g, o4b;
  logic        o1v, o2v, o3v, o4v;
  logic [15:0] dispatch_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rgb_first_dispatch dut (
    .clk(clk), .rst(rst),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_valid(in_valid), .in_ready(in_ready), .en_in(en_in),
    .out1_r(o1r), .out1_g(o1g), .out1_b(o1b), .out1_valid(o1v), .out1_ready(rdy[0]),
    .out2_r(o2r), .out2_g(o2g), .out2_b(o2b), .out2_valid(o2v), .out2_ready(rdy[1]),
    .out3_r(o3r), .out3_g(o3g), .out3_b(o3b), .out3_valid(o3v), .out3_ready(rdy[2]),
    .out4_r(o4r), .out4_g(o4g), .out4_b(o4b), .out4_valid(o4v), .out4_ready(rdy[3]),
    .dispatch_cnt(dispatch_cnt)
  );

  wire [3:0]  ov = {o4v, o3v, o2v, o1v};
  wire [23:0] od [4];
  assign od[0] = {o1r, o1g, o1b};
  assign od[1] = {o2r, o2g, o2b};
  assign od[2] = {o3r, o3g, o3b};
  assign od[3] = {o4r, o4g, o4b};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [23:0] p);
    in_valid = v;
    {in_r, in_g, in_b} = p;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; en_in = 4'b1111; rdy = 4'b0000;
    drive(1'b1, 24'h0);
    #1;
    check("in_ready_in_reset", in_ready, 0);
    step();
    check("rst_valid", ov, 4'b0000);
    check("rst_data1", od[0], 0);
    check("rst_cnt", dispatch_cnt, 0);

    // Fill channels in priority order, then stall.
    rst = 1'b1;
    drive(1'b1, 24'h112233);
    #1 check("fill_rdy0", in_ready, 1);
    step();
    check("fill_v0", ov, 4'b0001);
    check("fill_d0", od[0], 24'h112233);
    drive(1'b1, 24'h445566);
    for (int k = 1; k < 4; k++) begin
      check("fill_rdy", in_ready, 1);
      step();
      check("fill_v", ov, (4'b0001 << (k + 1)) - 4'b0001);
      check("fill_d", od[k], 24'h445566);
    end
    check("fill_stall", in_ready, 0);
    step();
    check("fill_cnt", dispatch_cnt, 4);
    check("fill_d0_hold", od[0], 24'h112233);

    // Only channel 3 enabled, all consumers ready.
    do_reset();
    en_in = 4'b0100; rdy = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 24'h0A0B0C + k * 24'h010203);
      #1 check("ch3_rdy", in_ready, 1);
      step();
      check("ch3_v", ov, 4'b0100);
      check("ch3_d", od[2], 24'h0A0B0C + k * 24'h010203);
    end
    check("ch3_cnt", dispatch_cnt, 10);

    // Drain and reload out1 in the same cycle.
    do_reset();
    en_in = 4'b1111; rdy = 4'b0000;
    drive(1'b1, 24'h010101);
    step();
    rdy = 4'b0001;
    drive(1'b1, 24'h020202);
    #1 check("reload_rdy", in_ready, 1);
    step();
    check("reload_v", ov, 4'b0001);
    check("reload_d", od[0], 24'h020202);

    // No enabled channel: nothing moves.
    rdy = 4'b0000; en_in = 4'b0000;
    drive(1'b1, 24'h999999);
    #1 check("noen_rdy", in_ready, 0);
    step();
    check("noen_v", ov, 4'b0001);
    check("noen_d", od[0], 24'h020202);
    check("noen_cnt", dispatch_cnt, 2);

    // Disabling channel 1 keeps its held pixel until consumed.
    en_in = 4'b0001; rdy = 4'b0001;
    drive(1'b1, 24'hAABBCC);
    step();
    en_in = 4'b1110; rdy = 4'b0000;
    drive(1'b0, 24'h0);
    step(); step();
    check("dis_v", ov, 4'b0001);
    check("dis_d", od[0], 24'hAABBCC);
    rdy = 4'b0001;
    step();
    check("dis_drained", ov, 4'b0000);

    // Counter wrap.
    do_reset();
    en_in = 4'b0001; rdy = 4'b1111;
    drive(1'b1, 24'h123456);
    for (int k = 0; k < 65535; k++) step();
    check("cnt_ffff", dispatch_cnt, 16'hFFFF);
    step();
    check("cnt_wrap", dispatch_cnt, 16'h0000);

    // Reset with all slots full.
    do_reset();
    en_in = 4'b1111; rdy = 4'b0000;
    drive(1'b1, 24'h777777);
    for (int k = 0; k < 4; k++) step();
    check("full_v", ov, 4'b1111);
    rst = 1'b0; rdy = 4'b1111;
    #1 check("midrst_rdy", in_ready, 0);
    step();
    check("midrst_v", ov, 4'b0000);
    check("midrst_d4", od[3], 0);
    check("midrst_cnt", dispatch_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rgb_first_dispatch.md
# rgb_first_dispatch

Pixel-stream distributor: accepts one 24-bit RGB pixel per cycle on a ready/valid input and delivers it to the lowest-indexed enabled output channel able to take it. It is the demux counterpart of the priority-first RGB selector. It sits between a pixel source and up to four parallel pixel consumers, such as processing lanes. Each output is a registered one-entry slot with its own ready/valid handshake.

## Interface
Parameters:
- NUM_CH, 4, number of output channels; only 4 is supported.
- CNT_W, 16, width of the accepted-pixel counter.

Ports:
- clk  input  1  sole clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-low; sampled on rising clk.
- in_r, in_g, in_b  input  8 each  incoming pixel components.
- in_valid  input  1  incoming pixel is present.
- in_ready  output  1  pixel accepted this cycle when in_valid && in_ready.
- en_in  input  4  per-channel enable; bit i = channel i+1.
- out1_r/g/b … out4_r/g/b  output  8 each  per-channel pixel registers.
- out1_valid … out4_valid  output  1 each  slot holds a pixel.
- out1_ready … out4_ready  input  1 each  consumer takes the pixel this cycle.
- dispatch_cnt  output  CNT_W  total pixels accepted since reset.

## Operation
- Slot i is free when it is empty (!outi_valid) or is draining this cycle (outi_valid && outi_ready).
- Candidate mask is free[i] && en_in[i].
- in_ready = |candidate. This is combinational from en_in, out*_valid and out*_ready.
- Target is the lowest index in the candidate mask (channel 1 has highest priority).
- On transfer (in_valid && in_ready):
  - the target slot loads in_r/g/b and sets valid=1;
  - dispatch_cnt increments by 1 modulo 2^CNT_W.
- Every other slot with valid && ready clears valid and holds its data.
- A non-target slot that is neither drained nor loaded keeps its data and valid.
- A slot drained and reloaded in the same cycle ends with valid=1 and the new data. There is no bubble.
- Clearing en_in[i] only stops new pixels going to slot i. A pixel already held there stays valid until its consumer takes it.
- in_valid with all candidates zero: in_ready=0. The source holds its data and no state changes.
- Data registers update only on load; their contents are don't-care while valid=0.
- Pixel order is preserved per channel. No ordering guarantee exists across channels.

## Timing
- Reset (rst=0 at an edge):
  - all out*_valid=0;
  - all out* data=0;
  - dispatch_cnt=0.
  - in_ready is 0 for the whole reset cycle, whatever the inputs.
- Reset mid-operation discards held pixels; no pending transfer completes.
- Latency: a pixel accepted at edge N is visible with valid at the output after edge N (one cycle).
- Throughput: one pixel per cycle while any enabled slot is free.
- Output handshake: valid, once set, stays high and data stays stable until the cycle where ready=1.
- Counter: wraps from 0xFFFF to 0x0000 on the next accept. There is no saturation.

## Structure
- Shared package rgb_pkg holds:
  - typedef struct packed {r,g,b} rgb_t, each component logic [7:0];
  - localparam NUM_CH=4.
  - The flattened port names follow the struct members.
- Sub-module rgb_out_slot: one registered slot with inputs load, pix, ready and outputs valid, data, free. It is instantiated NUM_CH times.
- Top-level logic holds the priority encoder for the target, in_ready and the counter.

## Test plan
- Reset then idle, all ready=0, en_in=4'b1111. Drive in pixel 0x112233 with valid, then 0x445566 for 4 cycles. Expected: channels 1..4 fill in order, then in_ready=0, and dispatch_cnt=4.
- en_in=4'b0100, all ready=1, stream of 10 pixels. Expected: every pixel appears only on out3 one cycle after accept, and in_ready stays 1.
- out1 full with out1_ready=1 and a new pixel arriving. Expected: out1 reloads the same cycle with valid staying 1 and new data, and no pixel goes to out2.
- en_in=0 with in_valid=1. Expected: in_ready=0 and no output changes. Then clear en_in[0] while out1 holds 0xAABBCC. Expected: 0xAABBCC remains until out1_ready.
- Preload dispatch_cnt to 0xFFFF with 65535 accepts, then accept one more. Expected: dispatch_cnt=0x0000.
- Assert rst=0 mid-stream with slots full. Expected: next cycle all valid=0, data=0, cnt=0, in_ready=0 during reset.
